// File: rtl/count_seq_checker.sv
// Sequence checker for a 4-bit up counter: locks on q_in, counts wraps and errors.
// Optional CNT_CHK_CAPTURE_EN adds exp_val/act_val capture of the first error.
module count_seq_checker #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        q_in,
  input  logic              chk_en,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [7:0]        err_cnt
`ifdef CNT_CHK_CAPTURE_EN
  ,
  output logic [3:0]        exp_val,
  output logic [3:0]        act_val
`endif
);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERROR} state_t;

  state_t     state;
  logic [3:0] prev;
  logic [3:0] prev_inc;
  logic       legal;
  logic       is_wrap;

`ifdef CNT_CHK_CAPTURE_EN
  logic captured;
`endif

  // A zero sample is an upstream reset, unless it repeats a zero (stall).
  always_comb begin
    prev_inc = prev + 4'd1;
    legal    = (q_in == prev_inc) || ((q_in == 4'd0) && (prev != 4'd0));
    is_wrap  = (prev == 4'hF) && (q_in == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
`ifdef CNT_CHK_CAPTURE_EN
      captured   <= 1'b0;
      exp_val    <= '0;
      act_val    <= '0;
`endif
    end else begin
      wrap_pulse <= 1'b0;
      if (!chk_en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
          SYNC: begin
            prev   <= q_in;
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            if (legal) begin
              prev <= q_in;
              if (is_wrap) begin
                wrap_pulse <= 1'b1;
                wrap_cnt   <= wrap_cnt + 1'b1;
              end
            end else begin
              err    <= 1'b1;
              state  <= ERROR;
              locked <= 1'b0;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef CNT_CHK_CAPTURE_EN
              if (!captured) begin
                captured <= 1'b1;
                exp_val  <= prev_inc;
                act_val  <= q_in;
              end
`endif
            end
          end
          ERROR: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over any same-cycle statistic update; FSM moves on untouched.
      if (clr) begin
        wrap_cnt <= '0;
        err      <= 1'b0;
        err_cnt  <= '0;
`ifdef CNT_CHK_CAPTURE_EN
        captured <= 1'b0;
        exp_val  <= '0;
        act_val  <= '0;
`endif
      end
    end
  end

endmodule
